// File: rtl/syntzulu_pkg.sv
// Shared definitions for the LIF layer scheduler.
//   sched_state_t : scheduler FSM states
//   DECAY_W       : width of the Q2.12 decay factor
//   DECAY_FRAC    : fractional bits of the decay factor
package syntzulu_pkg;

  localparam int unsigned DECAY_W    = 14;
  localparam int unsigned DECAY_FRAC = 12;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDrain,
    StClear,
    StDone
  } sched_state_t;

endpackage

// File: rtl/lif_layer_scheduler.sv
// Streams every neuron of a layer through one external LIF integrator, one neuron per cycle.
// A timestep reads membrane state and stimulus, feeds the integrator, writes results back in
// issue order and emits one event per spike. A clear sweep zeroes all membrane state instead.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   start, clear                     begin timestep (clear=0) or zero sweep (clear=1), IDLE only
//   detection, decay, threshold      per-layer config, latched on an accepted start
//   busy, done, spike_count          status; done pulses once at sweep end
//   mem_raddr/mem_rdata              state RAM read port (1-cycle latency)
//   stim_addr/stim_rdata             stimulus RAM read port (1-cycle latency)
//   mem_we/mem_waddr/mem_wdata       state RAM write port
//   int_*                            integrator inputs and outputs
//   spike_valid/spike_id             spike event stream, no backpressure
module lif_layer_scheduler
  import syntzulu_pkg::*;
#(
  parameter int unsigned WIDTH     = 25,
  parameter int unsigned N_NEURONS = 64,
  parameter int unsigned ADDR_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  parameter int unsigned PIPE_LAT  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic               detection,
  input  logic [DECAY_W-1:0] decay,
  input  logic [WIDTH-1:0]   threshold,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    spike_count,
  output logic [ADDR_W-1:0]  mem_raddr,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic [ADDR_W-1:0]  stim_addr,
  input  logic [WIDTH-1:0]   stim_rdata,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic               int_en,
  output logic [WIDTH-1:0]   int_output_old,
  output logic [WIDTH-1:0]   int_stimolo,
  output logic [DECAY_W-1:0] int_decay,
  output logic [WIDTH-1:0]   int_threshold,
  output logic               int_detection,
  input  logic               int_valid,
  input  logic               int_spike,
  input  logic [WIDTH-1:0]   int_output_new,
  output logic               spike_valid,
  output logic [ADDR_W-1:0]  spike_id
);

  // Results are matched to addresses purely by arrival order, so the integrator must be a
  // fixed-latency pipeline.
  if (PIPE_LAT < 1) begin : g_bad_pipe_lat
    $error("lif_layer_scheduler: PIPE_LAT must be at least 1");
  end

  localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(N_NEURONS - 1);

  sched_state_t       state_q;
  logic [ADDR_W:0]    rd_idx_q;
  logic [ADDR_W:0]    wb_idx_q;
  logic               int_en_q;
  logic [ADDR_W:0]    spike_count_q;
  logic               detection_q;
  logic [DECAY_W-1:0] decay_q;
  logic [WIDTH-1:0]   threshold_q;

  logic wb_fire;

  // Integrator results count only while a timestep is in flight.
  assign wb_fire = int_valid & ((state_q == StIssue) | (state_q == StDrain));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rd_idx_q      <= '0;
      wb_idx_q      <= '0;
      int_en_q      <= 1'b0;
      spike_count_q <= '0;
      detection_q   <= 1'b0;
      decay_q       <= '0;
      threshold_q   <= '0;
    end else begin
      // Read data for the address driven in ISSUE arrives one cycle later.
      int_en_q <= (state_q == StIssue);

      unique case (state_q)
        StIdle: begin
          if (start) begin
            detection_q   <= detection;
            decay_q       <= decay;
            threshold_q   <= threshold;
            spike_count_q <= '0;
            rd_idx_q      <= '0;
            wb_idx_q      <= '0;
            state_q       <= clear ? StClear : StIssue;
          end
        end
        StIssue: begin
          rd_idx_q <= rd_idx_q + 1'b1;
          if (rd_idx_q == LastIdx) state_q <= StDrain;
        end
        StDrain: ;
        StClear: begin
          wb_idx_q <= wb_idx_q + 1'b1;
          if (wb_idx_q == LastIdx) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (wb_fire) begin
        wb_idx_q <= wb_idx_q + 1'b1;
        if (int_spike) spike_count_q <= spike_count_q + 1'b1;
        if (wb_idx_q == LastIdx) state_q <= StDone;
      end
    end
  end

  always_comb begin
    mem_raddr   = '0;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    spike_valid = 1'b0;
    spike_id    = '0;

    if (state_q == StIssue) mem_raddr = rd_idx_q[ADDR_W-1:0];

    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = wb_idx_q[ADDR_W-1:0];
    end else if (wb_fire) begin
      mem_we    = 1'b1;
      mem_waddr = wb_idx_q[ADDR_W-1:0];
      mem_wdata = int_output_new;
      if (int_spike) begin
        spike_valid = 1'b1;
        spike_id    = wb_idx_q[ADDR_W-1:0];
      end
    end
  end

  assign stim_addr      = mem_raddr;
  assign int_en         = int_en_q;
  // RAM data is forwarded unregistered; gating keeps the bus quiet outside issue slots.
  assign int_output_old = int_en_q ? mem_rdata : '0;
  assign int_stimolo    = int_en_q ? stim_rdata : '0;
  assign int_decay      = decay_q;
  assign int_threshold  = threshold_q;
  assign int_detection  = detection_q;
  assign spike_count    = spike_count_q;
  assign busy           = (state_q == StIssue) | (state_q == StDrain) | (state_q == StClear);
  assign done           = (state_q == StDone);

endmodule

// File: tb/tb_lif_layer_scheduler.sv
module tb_lif_layer_scheduler;

  localparam int W  = 25;
  localparam int N  = 8;
  localparam int AW = 3;
  localparam int PL = 4;

  logic          clk, rst_n;
  logic          start, clear, detection;
  logic [13:0]   decay;
  logic [W-1:0]  threshold;
  logic          busy, done;
  logic [AW:0]   spike_count;
  logic [AW-1:0] mem_raddr, stim_addr, mem_waddr, spike_id;
  logic [W-1:0]  mem_rdata, stim_rdata, mem_wdata;
  logic          mem_we, int_en, int_detection, int_valid, int_spike, spike_valid;
  logic [W-1:0]  int_output_old, int_stimolo, int_threshold, int_output_new;
  logic [13:0]   int_decay;

  lif_layer_scheduler #(
    .WIDTH(W), .N_NEURONS(N), .ADDR_W(AW), .PIPE_LAT(PL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .detection(detection),
    .decay(decay), .threshold(threshold), .busy(busy), .done(done),
    .spike_count(spike_count), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .stim_addr(stim_addr), .stim_rdata(stim_rdata), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .int_en(int_en), .int_output_old(int_output_old),
    .int_stimolo(int_stimolo), .int_decay(int_decay), .int_threshold(int_threshold),
    .int_detection(int_detection), .int_valid(int_valid), .int_spike(int_spike),
    .int_output_new(int_output_new), .spike_valid(spike_valid), .spike_id(spike_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // LIF rule of the stand-in integrator: v' = (v * decay) >>> 12 + stim, fire and reset on
  // v' >= threshold when detection is on.
  function automatic logic [W:0] lif(input logic [W-1:0] v, input logic [W-1:0] s,
                                     input logic [13:0] d, input logic [W-1:0] th,
                                     input logic det);
    longint p;
    logic [W-1:0] n;
    p = (longint'($signed(v)) * longint'(d)) >>> 12;
    n = W'(p + longint'($signed(s)));
    if (det && ($signed(n) >= $signed(th))) return {1'b1, {W{1'b0}}};
    return {1'b0, n};
  endfunction

  // Memories and integrator surrounding the scheduler.
  logic [W-1:0] ram[N];
  logic [W-1:0] stim_m[N];
  logic [W-1:0] init_mem[N];
  logic         ld_all;

  always @(posedge clk) begin
    if (ld_all) begin
      for (int i = 0; i < N; i++) ram[i] <= init_mem[i];
    end else if (mem_we) begin
      ram[mem_waddr] <= mem_wdata;
    end
    mem_rdata  <= ram[mem_raddr];
    stim_rdata <= stim_m[stim_addr];
  end

  logic [PL-1:0] pv;
  logic [W-1:0]  pd[PL];
  logic          ps[PL];
  logic [W:0]    lif_in;
  logic          inj_v, inj_s;
  logic [W-1:0]  inj_d;

  assign lif_in = lif(int_output_old, int_stimolo, int_decay, int_threshold, int_detection);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      pv    <= {pv[PL-2:0], int_en};
      pd[0] <= lif_in[W-1:0];
      ps[0] <= lif_in[W];
      for (int i = 1; i < PL; i++) begin
        pd[i] <= pd[i-1];
        ps[i] <= ps[i-1];
      end
    end
  end

  assign int_valid      = pv[PL-1] | inj_v;
  assign int_spike      = inj_v ? inj_s : ps[PL-1];
  assign int_output_new = inj_v ? inj_d : pd[PL-1];

  // Reference model state.
  logic [W-1:0] ref_mem[N];
  logic [W-1:0] exp_new[N];
  bit           exp_sp[N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".spike_count"}, spike_count, 0);
    chk({tag, ".mem_raddr"}, mem_raddr, 0);
    chk({tag, ".stim_addr"}, stim_addr, 0);
    chk({tag, ".mem_we"}, mem_we, 0);
    chk({tag, ".mem_waddr"}, mem_waddr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".int_en"}, int_en, 0);
    chk({tag, ".int_output_old"}, int_output_old, 0);
    chk({tag, ".int_stimolo"}, int_stimolo, 0);
    chk({tag, ".int_decay"}, int_decay, 0);
    chk({tag, ".int_threshold"}, int_threshold, 0);
    chk({tag, ".int_detection"}, int_detection, 0);
    chk({tag, ".spike_valid"}, spike_valid, 0);
    chk({tag, ".spike_id"}, spike_id, 0);
  endtask

  task automatic load_mem();
    for (int i = 0; i < N; i++) init_mem[i] = ref_mem[i];
    @(negedge clk);
    ld_all = 1'b1;
    @(negedge clk);
    ld_all = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_val();
    int x;
    x = int'($urandom_range(0, 2097151)) - 1048576;
    return W'(x);
  endfunction

  // One full sweep; every cycle from start to one past done is compared against the
  // schedule implied by the timing rules.
  task automatic run_op(input bit clr, input bit det, input logic [13:0] dec,
                        input logic [W-1:0] th, input bit poke);
    int L, cnt_run, exp_cnt, idx, ra_e;
    bit en_e, we_e, sv_e;
    logic [W:0] r;
    exp_cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (clr) begin
        exp_new[i] = '0;
        exp_sp[i]  = 1'b0;
      end else begin
        r = lif(ref_mem[i], stim_m[i], dec, th, det);
        exp_new[i] = r[W-1:0];
        exp_sp[i]  = r[W];
        exp_cnt += int'(r[W]);
      end
    end
    L = clr ? N + 1 : N + PL + 2;
    @(negedge clk);
    start = 1'b1; clear = clr; detection = det; decay = dec; threshold = th;
    @(negedge clk);
    // Scramble config inputs: the outputs must keep the latched values.
    start = 1'b0; clear = ~clr; detection = ~det; decay = ~dec; threshold = ~th;
    cnt_run = 0;
    for (int t = 1; t <= L + 1; t++) begin
      en_e = !clr && t >= 2 && t <= N + 1;
      ra_e = (!clr && t <= N) ? t - 1 : 0;
      if (clr) begin
        we_e = t <= N;
        idx  = t - 1;
      end else begin
        we_e = t >= PL + 2 && t <= PL + N + 1;
        idx  = t - PL - 2;
      end
      sv_e = we_e && !clr && exp_sp[idx];
      chk("busy", busy, 64'(t < L));
      chk("done", done, 64'(t == L));
      chk("int_en", int_en, 64'(en_e));
      chk("mem_raddr", mem_raddr, 64'(ra_e));
      chk("stim_addr", stim_addr, 64'(ra_e));
      chk("mem_we", mem_we, 64'(we_e));
      if (we_e) begin
        chk("mem_waddr", mem_waddr, 64'(idx));
        chk("mem_wdata", mem_wdata, 64'(exp_new[idx]));
      end
      chk("spike_valid", spike_valid, 64'(sv_e));
      if (sv_e) chk("spike_id", spike_id, 64'(idx));
      chk("spike_count", spike_count, 64'(cnt_run));
      if (sv_e) cnt_run++;
      if (en_e) begin
        chk("int_output_old", int_output_old, 64'(ref_mem[t-2]));
        chk("int_stimolo", int_stimolo, 64'(stim_m[t-2]));
      end
      chk("int_decay", int_decay, 64'(dec));
      chk("int_threshold", int_threshold, 64'(th));
      chk("int_detection", int_detection, 64'(det));
      start = poke && (t == 3);
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      ref_mem[i] = exp_new[i];
      chk("ram_after_sweep", ram[i], 64'(ref_mem[i]));
    end
    chk("spike_count_final", spike_count, 64'(exp_cnt));
  endtask

  logic [W-1:0] lit;

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; detection = 1'b0; decay = '0; threshold = '0;
    inj_v = 1'b0; inj_s = 1'b0; inj_d = '0; ld_all = 1'b0;
    for (int i = 0; i < N; i++) begin
      ref_mem[i] = rnd_val();
      stim_m[i]  = rnd_val();
    end
    load_mem();
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Abort a timestep after three issues.
    @(negedge clk);
    start = 1'b1; clear = 1'b0; detection = 1'b1; decay = 14'd4096; threshold = 25'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort.busy_before", busy, 1);
    chk("abort.raddr_before", mem_raddr, 2);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("idle_after_abort");
    load_mem();

    // Clear sweep.
    run_op(1'b1, 1'b0, 14'd0, '0, 1'b0);
    for (int i = 0; i < N; i++) chk("clear_zero", ram[i], 0);

    // Accumulate 100 per step, fire on the third.
    for (int i = 0; i < N; i++) stim_m[i] = 25'd100;
    run_op(1'b0, 1'b1, 14'd4096, 25'd250, 1'b0);
    chk("step1_val", ram[0], 100);
    run_op(1'b0, 1'b1, 14'd4096, 25'd250, 1'b1);
    chk("step2_val", ram[N-1], 200);
    run_op(1'b0, 1'b1, 14'd4096, 25'd250, 1'b0);
    chk("step3_val", ram[2], 0);
    chk("step3_count", spike_count, N);

    // Same with detection off.
    run_op(1'b1, 1'b0, 14'd0, '0, 1'b0);
    for (int s = 0; s < 3; s++) run_op(1'b0, 1'b0, 14'd4096, 25'd250, 1'b0);
    chk("nodet_val", ram[5], 300);
    chk("nodet_count", spike_count, 0);

    // Half decay on a negative state.
    for (int i = 0; i < N; i++) begin
      ref_mem[i] = W'(-1000);
      stim_m[i]  = '0;
    end
    load_mem();
    run_op(1'b0, 1'b1, 14'd2048, 25'd250, 1'b0);
    lit = W'(-500);
    chk("neg_decay_val", ram[3], 64'(lit));

    // Spurious integrator results in IDLE.
    @(negedge clk);
    inj_v = 1'b1; inj_s = 1'b1; inj_d = 25'h1abcd;
    for (int c = 0; c < 3; c++) begin
      chk("idle_inj.mem_we", mem_we, 0);
      chk("idle_inj.spike_valid", spike_valid, 0);
      chk("idle_inj.spike_count", spike_count, 0);
      @(negedge clk);
    end
    inj_v = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) chk("idle_inj.ram", ram[i], 64'(ref_mem[i]));

    // Randomized timesteps.
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < N; i++) stim_m[i] = rnd_val();
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < N; i++) ref_mem[i] = rnd_val();
        load_mem();
      end
      run_op(($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
             14'($urandom_range(0, 8191)), W'($urandom_range(0, 400000)),
             1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lif_layer_scheduler.md
# lif_layer_scheduler

Sequences one LIF integrator pipeline across all neurons of a layer, one neuron per cycle, for each timestep. On `start` it streams membrane state and input stimulus from two synchronous RAMs into the integrator, writes each updated membrane value back in issue order and emits one spike event per firing neuron. It sits between the layer controller (start/done, per-layer config) and the integrator instance plus state/stimulus memories. It also provides a clear sweep that zeroes all membrane state.

## Interface
- `WIDTH`, 25, membrane/stimulus/threshold width.
- `N_NEURONS`, 64, neurons per layer (≥1).
- `ADDR_W`, $clog2(N_NEURONS) (min 1), neuron address width.
- `PIPE_LAT`, 4, integrator latency from `int_en` to `int_valid`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin timestep (or clear), sampled only in IDLE.
- `clear` in 1: sampled with `start`; 1 = zero sweep instead of timestep.
- `detection` in 1: spike enable, latched at `start`.
- `decay` in 14: Q2.12 decay, latched at `start`.
- `threshold` in WIDTH: latched at `start`.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse at sweep end.
- `spike_count` out ADDR_W+1: spikes this timestep, held until next `start`.
- `mem_raddr` out ADDR_W, `mem_rdata` in WIDTH: state RAM read, 1-cycle latency.
- `stim_addr` out ADDR_W, `stim_rdata` in WIDTH: stimulus RAM read, 1-cycle latency.
- `mem_we` out 1, `mem_waddr` out ADDR_W, `mem_wdata` out WIDTH: state RAM write.
- `int_en` out 1, `int_output_old` out WIDTH, `int_stimolo` out WIDTH, `int_decay` out 14, `int_threshold` out WIDTH, `int_detection` out 1: integrator inputs.
- `int_valid` in 1, `int_spike` in 1, `int_output_new` in WIDTH: integrator outputs.
- `spike_valid` out 1, `spike_id` out ADDR_W: spike event, no backpressure.

## Operation
- States: IDLE, ISSUE, DRAIN, CLEAR, DONE.
- IDLE → ISSUE on `start & ~clear`. IDLE → CLEAR on `start & clear`. Both transitions latch config, zero `spike_count`, zero the issue and writeback counters and set `busy`.
- ISSUE:
  - Cycle k drives `mem_raddr = stim_addr = rd_idx` and increments `rd_idx`.
  - Cycle k+1 asserts `int_en` with `int_output_old = mem_rdata` and `int_stimolo = stim_rdata`.
  - After address N−1 is driven, go to DRAIN.
- Writeback runs in ISSUE and DRAIN:
  - Each `int_valid` sets `mem_we = 1`, `mem_waddr = wb_idx`, `mem_wdata = int_output_new`, then increments `wb_idx`.
  - If `int_spike` is also high: `spike_valid = 1`, `spike_id = wb_idx`, and `spike_count` +1.
  - Results return in order, so no address tag FIFO is needed.
- DRAIN → DONE when the writeback for index N−1 occurs.
- CLEAR: one write per cycle of `mem_wdata = 0` to addresses 0..N−1. No reads, no `int_en`. After address N−1, go to DONE.
- DONE: `done = 1` for one cycle, `busy` falls, return to IDLE.
- `int_decay`, `int_threshold` and `int_detection` drive the latched values continuously.
- `int_valid` outside ISSUE/DRAIN is ignored: no write, no count.
- `start` while busy is ignored.
- Counters wrap-safe: `rd_idx` and `wb_idx` are ADDR_W+1 bits wide and compared against N_NEURONS.

## Timing
- Reset (async assert, sync release): state IDLE. All outputs 0, including `busy`, `done`, `mem_we`, `int_en`, `spike_valid`, `spike_count`, all addresses and data.
- Assertion mid-sweep aborts immediately; state RAM contents for that timestep are undefined.
- `start` at cycle 0 → first `int_en` at cycle 2 → first `mem_we` at cycle 2+PIPE_LAT.
- Timestep length: `done` at cycle N+PIPE_LAT+2, i.e. N+6 cycles after `start`.
- Clear length: `done` at cycle N+1.
- Throughput: one neuron per cycle, no bubbles.
- Read/write hazard: none. Each address is read once per sweep, before its writeback.
- N_NEURONS=1: ISSUE lasts one cycle; all timing formulas still hold.

## Structure
- Shared package `syntzulu_pkg`: state enum `sched_state_t`, `DECAY_W = 14`, `DECAY_FRAC = 12`.
- No sub-module. The integrator is instantiated beside this block at layer level, not inside it.

## Test plan
- Reset mid-ISSUE (N=8, abort after 3 issues) → all outputs 0 asynchronously, IDLE. Next `start` runs a full sweep.
- Clear sweep, N=4 → `mem_we` at cycles 1..4 with addresses 0..3 and data 0; `done` at cycle 5; no `int_en`.
- N=4, state 0, stim 100, threshold 250, decay 4096, detection 1, three timesteps:
  - stored values 100, then 200.
  - third step: 4 spikes with ids 0..3, `spike_count = 4`, stored 0.
- Same setup with detection 0 → stored 300 after step 3, no spikes.
- Decay 2048, state −1000, stim 0 → written −500 (sign-correct shift). `done` exactly N+6 cycles after `start`.
- `start` pulsed during busy, and spurious `int_valid` in IDLE → both ignored; memory and counters unchanged.
